// File: rtl/nios2_div_pkg.sv
// Shared types and constants for the Nios II M-stage iterative divider.
package nios2_div_pkg;
    localparam int WIDTH = 32;

    typedef enum logic [1:0] {IDLE, PREP, ITER, FIXUP} div_state_t;

    typedef logic [4:0] div_cnt_t;

    localparam logic [WIDTH-1:0] DIV_ZERO_Q = 32'hFFFF_FFFF;
endpackage

// File: rtl/nios2_div_step.sv
// One radix-2 restoring division step: shift in the next dividend bit, trial subtract.
module nios2_div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_rem,
    input  logic             i_msb,
    input  logic [WIDTH-1:0] i_dvs,
    output logic [WIDTH-1:0] o_rem,
    output logic             o_qbit
);
    logic [WIDTH:0]   w_shift;
    logic [WIDTH-1:0] w_diff;

    assign w_shift = {i_rem, i_msb};
    // When the compare succeeds the difference is below the divisor, so it fits in WIDTH bits.
    assign o_qbit  = (w_shift >= {1'b0, i_dvs});
    assign w_diff  = w_shift[WIDTH-1:0] - i_dvs;
    assign o_rem   = o_qbit ? w_diff : w_shift[WIDTH-1:0];
endmodule

// File: rtl/nios2_div_cell.sv
// Iterative 32-bit signed/unsigned divider: fixed 34-cycle latency, registered results.
module nios2_div_cell #(
    parameter int WIDTH = nios2_div_pkg::WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] M_div_src1,
    input  logic [WIDTH-1:0] M_div_src2,
    input  logic             M_div_signed,
    input  logic             M_div_start,
    input  logic             M_div_abort,
    output logic             M_div_busy,
    output logic             M_div_done,
    output logic [WIDTH-1:0] M_div_quotient,
    output logic [WIDTH-1:0] M_div_remainder
);
    import nios2_div_pkg::*;

    div_state_t       r_state, w_state_nxt;
    div_cnt_t         r_cnt;
    logic             w_accept, w_finish;
    logic [WIDTH-1:0] r_src1, r_src2;
    logic             r_signed, r_neg_q, r_neg_r, r_dz;
    logic [WIDTH-1:0] r_dvd, r_dvs, r_rem;
    logic [WIDTH-1:0] r_quot, r_rem_out;
    logic             r_busy, r_done;
    logic [WIDTH-1:0] w_abs1, w_abs2, w_rem_nxt;
    logic             w_qbit;

    nios2_div_step #(.WIDTH(WIDTH)) u_step (
        .i_rem  (r_rem),
        .i_msb  (r_dvd[WIDTH-1]),
        .i_dvs  (r_dvs),
        .o_rem  (w_rem_nxt),
        .o_qbit (w_qbit)
    );

    assign w_abs1 = (r_signed && r_src1[WIDTH-1]) ? -r_src1 : r_src1;
    assign w_abs2 = (r_signed && r_src2[WIDTH-1]) ? -r_src2 : r_src2;

    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        case (r_state)
            IDLE: begin
                if (M_div_start && !M_div_abort) begin
                    w_accept    = 1'b1;
                    w_state_nxt = PREP;
                end
            end
            PREP:    w_state_nxt = ITER;
            ITER:    if (r_cnt == '0) w_state_nxt = FIXUP;
            FIXUP:   w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
        if (M_div_abort) w_state_nxt = IDLE;
        w_finish = (r_state == FIXUP) && !M_div_abort;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_quot    <= '0;
            r_rem_out <= '0;
            r_src1    <= '0;
            r_src2    <= '0;
            r_signed  <= 1'b0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_dz      <= 1'b0;
            r_dvd     <= '0;
            r_dvs     <= '0;
            r_rem     <= '0;
            r_cnt     <= '0;
        end else begin
            r_busy <= (w_state_nxt != IDLE);
            r_done <= w_finish;
            if (w_accept) begin
                r_src1   <= M_div_src1;
                r_src2   <= M_div_src2;
                r_signed <= M_div_signed;
                r_neg_q  <= M_div_signed & (M_div_src1[WIDTH-1] ^ M_div_src2[WIDTH-1]);
                r_neg_r  <= M_div_signed & M_div_src1[WIDTH-1];
                r_dz     <= (M_div_src2 == '0);
            end
            if (r_state == PREP) begin
                r_dvd <= w_abs1;
                r_dvs <= w_abs2;
                r_rem <= '0;
                r_cnt <= div_cnt_t'(WIDTH - 1);
            end
            // Quotient bits shift into the vacated low end of the dividend register.
            if (r_state == ITER) begin
                r_rem <= w_rem_nxt;
                r_dvd <= {r_dvd[WIDTH-2:0], w_qbit};
                r_cnt <= r_cnt - div_cnt_t'(1);
            end
            if (w_finish) begin
                r_quot    <= r_dz ? WIDTH'(DIV_ZERO_Q) : (r_neg_q ? -r_dvd : r_dvd);
                r_rem_out <= r_dz ? r_src1 : (r_neg_r ? -r_rem : r_rem);
            end
        end
    end

    assign M_div_busy      = r_busy;
    assign M_div_done      = r_done;
    assign M_div_quotient  = r_quot;
    assign M_div_remainder = r_rem_out;
endmodule

// File: tb/tb_nios2_div_cell.sv
// Directed-vector bench for nios2_div_cell: results, latency, busy/done timing, start/abort/reset rules.
module tb_nios2_div_cell;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] src1 = '0, src2 = '0;
    logic        sgn = 1'b0, start = 1'b0, abort = 1'b0;
    logic        busy, done;
    logic [31:0] quot, rem;

    int n_vec = 0;
    int n_err = 0;

    nios2_div_cell #(.WIDTH(32)) dut (
        .clk             (clk),
        .reset           (reset),
        .M_div_src1      (src1),
        .M_div_src2      (src2),
        .M_div_signed    (sgn),
        .M_div_start     (start),
        .M_div_abort     (abort),
        .M_div_busy      (busy),
        .M_div_done      (done),
        .M_div_quotient  (quot),
        .M_div_remainder (rem)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    // Returns at #1 after the accepting edge (cycle offset k = 0).
    task automatic do_start(input logic [31:0] a, input logic [31:0] b, input logic s);
        @(negedge clk);
        src1 = a; src2 = b; sgn = s; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                           output logic [31:0] q, output logic [31:0] r,
                           output int lat, output int bcnt);
        do_start(a, b, s);
        lat = -1; bcnt = 0; q = '0; r = '0;
        for (int k = 0; k <= 60; k++) begin
            if (k > 0) begin @(posedge clk); #1; end
            if (busy) bcnt++;
            if (done) begin lat = k; q = quot; r = rem; break; end
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; start = 1'b1; src1 = 32'd9; src2 = 32'd3;
        repeat (3) @(posedge clk);
        #1;
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
        n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done got %b want 0", done); end
        n_vec++; if (quot !== 32'h0) begin n_err++; $display("FAIL reset_quot got %h want 0", quot); end
        n_vec++; if (rem !== 32'h0) begin n_err++; $display("FAIL reset_rem got %h want 0", rem); end
        start = 1'b0;
        @(negedge clk); reset = 1'b0;
    endtask

    task automatic test_unsigned;
        logic [31:0] q, r; int lat, bc;
        run_div(32'd100, 32'd7, 1'b0, q, r, lat, bc);
        n_vec++; if (q !== 32'd14) begin n_err++; $display("FAIL u100_7_quot got %h want e", q); end
        n_vec++; if (r !== 32'd2) begin n_err++; $display("FAIL u100_7_rem got %h want 2", r); end
        n_vec++; if (lat != 34) begin n_err++; $display("FAIL u100_7_latency got %0d want 34", lat); end
        n_vec++; if (bc != 34) begin n_err++; $display("FAIL u100_7_busy_cycles got %0d want 34", bc); end
        @(posedge clk); #1;
        n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL done_single_cycle got %b want 0", done); end
        n_vec++; if (quot !== 32'd14) begin n_err++; $display("FAIL quot_held got %h want e", quot); end
    endtask

    task automatic test_signed;
        logic [31:0] q, r; int lat, bc;
        run_div(32'hFFFF_FF9C, 32'd7, 1'b1, q, r, lat, bc);
        n_vec++; if (q !== 32'hFFFF_FFF2) begin n_err++; $display("FAIL sneg100_7_quot got %h want fffffff2", q); end
        n_vec++; if (r !== 32'hFFFF_FFFE) begin n_err++; $display("FAIL sneg100_7_rem got %h want fffffffe", r); end
        run_div(32'd100, 32'hFFFF_FFF9, 1'b1, q, r, lat, bc);
        n_vec++; if (q !== 32'hFFFF_FFF2) begin n_err++; $display("FAIL s100_neg7_quot got %h want fffffff2", q); end
        n_vec++; if (r !== 32'd2) begin n_err++; $display("FAIL s100_neg7_rem got %h want 2", r); end
        run_div(32'hFFFF_FF9C, 32'hFFFF_FFF9, 1'b1, q, r, lat, bc);
        n_vec++; if (q !== 32'd14) begin n_err++; $display("FAIL sneg_neg_quot got %h want e", q); end
        n_vec++; if (r !== 32'hFFFF_FFFE) begin n_err++; $display("FAIL sneg_neg_rem got %h want fffffffe", r); end
        n_vec++; if (lat != 34) begin n_err++; $display("FAIL signed_latency got %0d want 34", lat); end
    endtask

    task automatic test_overflow;
        logic [31:0] q, r; int lat, bc;
        run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, q, r, lat, bc);
        n_vec++; if (q !== 32'h8000_0000) begin n_err++; $display("FAIL sovf_quot got %h want 80000000", q); end
        n_vec++; if (r !== 32'h0) begin n_err++; $display("FAIL sovf_rem got %h want 0", r); end
        run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, q, r, lat, bc);
        n_vec++; if (q !== 32'h0) begin n_err++; $display("FAIL uovf_quot got %h want 0", q); end
        n_vec++; if (r !== 32'h8000_0000) begin n_err++; $display("FAIL uovf_rem got %h want 80000000", r); end
    endtask

    task automatic test_div_zero;
        logic [31:0] q, r; int lat, bc;
        run_div(32'h1234_5678, 32'h0, 1'b1, q, r, lat, bc);
        n_vec++; if (q !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL sdz_quot got %h want ffffffff", q); end
        n_vec++; if (r !== 32'h1234_5678) begin n_err++; $display("FAIL sdz_rem got %h want 12345678", r); end
        n_vec++; if (lat != 34) begin n_err++; $display("FAIL sdz_latency got %0d want 34", lat); end
        run_div(32'h1234_5678, 32'h0, 1'b0, q, r, lat, bc);
        n_vec++; if (q !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL udz_quot got %h want ffffffff", q); end
        n_vec++; if (r !== 32'h1234_5678) begin n_err++; $display("FAIL udz_rem got %h want 12345678", r); end
        n_vec++; if (lat != 34) begin n_err++; $display("FAIL udz_latency got %0d want 34", lat); end
        run_div(32'h8765_4321, 32'h0, 1'b1, q, r, lat, bc);
        n_vec++; if (q !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL sdzneg_quot got %h want ffffffff", q); end
        n_vec++; if (r !== 32'h8765_4321) begin n_err++; $display("FAIL sdzneg_rem got %h want 87654321", r); end
    endtask

    task automatic test_back_to_back;
        logic [31:0] q, r; int lat, bc;
        run_div(32'd100, 32'd7, 1'b0, q, r, lat, bc);
        run_div(32'hFFFF_FFCE, 32'd3, 1'b1, q, r, lat, bc);
        n_vec++; if (q !== 32'hFFFF_FFF0) begin n_err++; $display("FAIL b2b_quot got %h want fffffff0", q); end
        n_vec++; if (r !== 32'hFFFF_FFFE) begin n_err++; $display("FAIL b2b_rem got %h want fffffffe", r); end
        n_vec++; if (lat != 34) begin n_err++; $display("FAIL b2b_latency got %0d want 34", lat); end
    endtask

    task automatic test_start_busy;
        int nd = 0, lat = -1;
        logic [31:0] q = '0, r = '0;
        do_start(32'd1000, 32'd10, 1'b0);
        for (int k = 1; k <= 60; k++) begin
            @(posedge clk); #1;
            if (done) begin nd++; if (lat < 0) lat = k; q = quot; r = rem; end
            if (k == 4 || k == 19) begin src1 = 32'd5; src2 = 32'd1; start = 1'b1; end
            else start = 1'b0;
        end
        n_vec++; if (nd != 1) begin n_err++; $display("FAIL busy_start_done_count got %0d want 1", nd); end
        n_vec++; if (lat != 34) begin n_err++; $display("FAIL busy_start_latency got %0d want 34", lat); end
        n_vec++; if (q !== 32'd100) begin n_err++; $display("FAIL busy_start_quot got %h want 64", q); end
        n_vec++; if (r !== 32'd0) begin n_err++; $display("FAIL busy_start_rem got %h want 0", r); end
        n_vec++; if (quot !== 32'd100) begin n_err++; $display("FAIL busy_start_held got %h want 64", quot); end
    endtask

    task automatic test_abort;
        int nd = 0, lat = -1;
        logic [31:0] q = '0, r = '0;
        do_start(32'd77, 32'd7, 1'b0);
        for (int k = 1; k <= 60; k++) begin
            @(posedge clk); #1;
            if (done) begin nd++; if (lat < 0) lat = k; q = quot; r = rem; end
            if (k == 10) begin
                n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL abort_busy got %b want 0", busy); end
            end
            if (k == 20) begin
                n_vec++; if (quot !== 32'd100) begin n_err++; $display("FAIL abort_held got %h want 64", quot); end
            end
            abort = (k == 9);
            if (k == 11) begin src1 = 32'd200; src2 = 32'd9; start = 1'b1; end
            else start = 1'b0;
        end
        n_vec++; if (nd != 1) begin n_err++; $display("FAIL abort_done_count got %0d want 1", nd); end
        n_vec++; if (lat != 46) begin n_err++; $display("FAIL abort_restart_at got %0d want 46", lat); end
        n_vec++; if (q !== 32'd22) begin n_err++; $display("FAIL abort_restart_quot got %h want 16", q); end
        n_vec++; if (r !== 32'd2) begin n_err++; $display("FAIL abort_restart_rem got %h want 2", r); end
        // Abort together with start in IDLE drops the start.
        @(negedge clk);
        src1 = 32'd9; src2 = 32'd3; start = 1'b1; abort = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL abort_start_idle_busy got %b want 0", busy); end
        nd = 0;
        for (int k = 0; k < 40; k++) begin @(posedge clk); #1; if (done) nd++; end
        n_vec++; if (nd != 0) begin n_err++; $display("FAIL abort_start_idle_done got %0d want 0", nd); end
    endtask

    task automatic test_reset_mid;
        logic [31:0] q, r; int lat, bc, nd;
        do_start(32'hFFFF_FFFF, 32'd7, 1'b0);
        for (int k = 1; k <= 16; k++) begin @(posedge clk); #1; end
        reset = 1'b1;
        @(posedge clk); #1;
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL midreset_busy got %b want 0", busy); end
        n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL midreset_done got %b want 0", done); end
        n_vec++; if (quot !== 32'h0) begin n_err++; $display("FAIL midreset_quot got %h want 0", quot); end
        n_vec++; if (rem !== 32'h0) begin n_err++; $display("FAIL midreset_rem got %h want 0", rem); end
        reset = 1'b0;
        nd = 0;
        for (int k = 0; k < 50; k++) begin @(posedge clk); #1; if (done) nd++; end
        n_vec++; if (nd != 0) begin n_err++; $display("FAIL midreset_no_done got %0d want 0", nd); end
        run_div(32'hFFFF_FFFF, 32'd1, 1'b0, q, r, lat, bc);
        n_vec++; if (q !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL fresh_quot got %h want ffffffff", q); end
        n_vec++; if (r !== 32'h0) begin n_err++; $display("FAIL fresh_rem got %h want 0", r); end
        n_vec++; if (lat != 34) begin n_err++; $display("FAIL fresh_latency got %0d want 34", lat); end
    endtask

    initial begin
        test_reset;
        test_unsigned;
        test_signed;
        test_overflow;
        test_div_zero;
        test_back_to_back;
        test_start_busy;
        test_abort;
        test_reset_mid;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
